fetch_buffer: RTL and testbench



---
 rtl/fetch_buffer.sv | 139 +++++++++++++
 tb/tb_fetch_buffer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// Instruction fetch front end: one-outstanding word fetch into a PC-tagged
// FIFO that feeds decode through valid/ready, flushed by redirect.
module fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   mem_req,
    output logic [31:0]            mem_addr,
    input  logic                   mem_ack,
    input  logic [31:0]            mem_rdata,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [31:0]            inst_out,
    output logic [31:0]            inst_pc,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   out_q, out_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [63:0]   buf_q [DEPTH];
    logic          push;
    logic          pop;
    logic [31:0]   redir_pc;

    assign mem_req    = (state_q != IDLE);
    assign mem_addr   = addr_q;
    assign inst_valid = (count_q != '0);
    assign inst_out   = out_q;
    assign inst_pc    = pc_q;
    assign count      = count_q;

    always_comb begin
        redir_pc   = redirect_pc & ~32'd3;
        pop        = inst_valid && inst_ready && !redirect;
        push       = (state_q == REQ) && mem_ack && !redirect;
        fetch_pc_d = fetch_pc_q;
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        out_d      = out_q;
        pc_d       = pc_q;

        if (redirect) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = redir_pc;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push) begin
                wr_ptr_d   = wr_ptr_q + AW'(1);
                fetch_pc_d = addr_q + 32'd4;
            end
            count_d = count_q + CW'(push) - CW'(pop);
            // An empty-after-pop FIFO takes its new head straight from the push.
            if (push && count_q == CW'(pop)) begin
                out_d = mem_rdata;
                pc_d  = addr_q;
            end else if (count_d != '0) begin
                {out_d, pc_d} = buf_q[rd_ptr_d];
            end
        end

        unique case (state_q)
            IDLE: begin
                if (count_d < FULL) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d = (count_d < FULL) ? REQ : IDLE;
                end else if (redirect) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_ack) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        // The stale request keeps its address until memory answers it.
        addr_d = (state_d == DRAIN) ? addr_q : fetch_pc_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            out_q      <= '0;
            pc_q       <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            out_q      <= out_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            buf_q[wr_ptr_q] <= {mem_rdata, addr_q};
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed vector table, hand-written corner
// sequences, and random traffic against a queue-based reference model.
module tb_fetch_buffer;
    localparam int          DEPTH = 4;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;

    logic        clock;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [2:0]  count;

    fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clock       (clock),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_out    (inst_out),
        .inst_pc     (inst_pc),
        .count       (count)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // 0: manual ack level, 1: fixed latency, 2: random acks with random data
    int mem_mode = 1;
    int lat      = 0;
    int waitc    = 0;
    bit man_ack  = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: decides the ack for each cycle just after the edge.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clock);
            #1;
            if (mem_mode == 0) begin
                mem_ack   = man_ack;
                mem_rdata = 32'hDEAD_BEEF;
            end else if (mem_mode == 1) begin
                if (mem_req && waitc >= lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_addr ^ KEY;
                    waitc     = 0;
                end else begin
                    mem_ack = 1'b0;
                    waitc   = mem_req ? waitc + 1 : 0;
                end
            end else begin
                mem_ack   = mem_req && ($urandom_range(0, 2) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    // Reference model: instruction queue plus one pending fetch that may be
    // marked as stale by a redirect.
    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_fpc  = 32'h0;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] m_hins = 32'h0;
    logic [31:0] m_hpc  = 32'h0;
    logic        m_req  = 1'b0;
    logic        m_drop = 1'b0;

    task automatic model_step();
        bit   take;
        ent_t e;
        take = (mq.size() != 0) && inst_ready && !redirect;
        if (redirect) begin
            mq.delete();
            m_fpc = redirect_pc & ~32'd3;
            if (m_req && !mem_ack) begin
                m_drop = 1'b1;
            end else begin
                m_drop = 1'b0;
                m_req  = 1'b1;
                m_addr = m_fpc;
            end
        end else begin
            if (take) begin
                void'(mq.pop_front());
            end
            if (m_req && mem_ack) begin
                if (!m_drop) begin
                    e.ins = mem_rdata;
                    e.pc  = m_addr;
                    mq.push_back(e);
                    m_fpc = m_addr + 32'd4;
                end
                m_drop = 1'b0;
                m_addr = m_fpc;
                m_req  = (mq.size() < DEPTH);
            end else if (!m_req) begin
                m_addr = m_fpc;
                m_req  = (mq.size() < DEPTH);
            end
        end
        if (mq.size() != 0) begin
            m_hins = mq[0].ins;
            m_hpc  = mq[0].pc;
        end
    endtask

    initial begin
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                mq.delete();
                m_fpc  = 32'h0;
                m_addr = 32'h0;
                m_hins = 32'h0;
                m_hpc  = 32'h0;
                m_req  = 1'b0;
                m_drop = 1'b0;
            end else begin
                model_step();
            end
        end
    end

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          redir;
        logic [31:0] rpc;
        bit          req;
        bit          ca;
        logic [31:0] addr;
        logic [2:0]  cnt;
        bit          val;
        logic [31:0] pc;
        logic [31:0] out;
    } vec_t;

    function automatic vec_t mk(bit rst, bit rdy, bit redir, logic [31:0] rpc,
                                bit req, bit ca, logic [31:0] addr,
                                logic [2:0] cnt, bit val, logic [31:0] pc,
                                logic [31:0] out);
        vec_t v;
        v.rst = rst;   v.rdy = rdy;  v.redir = redir; v.rpc = rpc;
        v.req = req;   v.ca = ca;    v.addr = addr;   v.cnt = cnt;
        v.val = val;   v.pc = pc;    v.out = out;
        return v;
    endfunction

    vec_t tbl [23];

    initial begin
        bit          found;
        int          n;
        logic [31:0] act_a;
        logic [31:0] exp_a;

        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        inst_ready  = 1'b1;

        // zero-wait fetch, decode always ready
        tbl[0]  = mk(1, 1, 0, 0, 0, 1, 32'h0,  0, 0, 32'h0, 32'h0);
        tbl[1]  = mk(0, 1, 0, 0, 1, 1, 32'h0,  0, 0, 32'h0, 32'h0);
        tbl[2]  = mk(0, 1, 0, 0, 1, 1, 32'h4,  1, 1, 32'h0, 32'hA5A5_0000);
        tbl[3]  = mk(0, 1, 0, 0, 1, 1, 32'h8,  1, 1, 32'h4, 32'hA5A5_0004);
        tbl[4]  = mk(0, 1, 0, 0, 1, 1, 32'hC,  1, 1, 32'h8, 32'hA5A5_0008);
        // decode stalled: fill to DEPTH, one pop restarts fetch at 16
        tbl[5]  = mk(1, 0, 0, 0, 0, 1, 32'h0,  0, 0, 32'h0, 32'h0);
        tbl[6]  = mk(0, 0, 0, 0, 1, 1, 32'h0,  0, 0, 32'h0, 32'h0);
        tbl[7]  = mk(0, 0, 0, 0, 1, 1, 32'h4,  1, 1, 32'h0, 32'hA5A5_0000);
        tbl[8]  = mk(0, 0, 0, 0, 1, 1, 32'h8,  2, 1, 32'h0, 32'hA5A5_0000);
        tbl[9]  = mk(0, 0, 0, 0, 1, 1, 32'hC,  3, 1, 32'h0, 32'hA5A5_0000);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 32'h0,  4, 1, 32'h0, 32'hA5A5_0000);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 32'h0,  4, 1, 32'h0, 32'hA5A5_0000);
        tbl[12] = mk(0, 1, 0, 0, 1, 1, 32'h10, 3, 1, 32'h4, 32'hA5A5_0004);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 32'h0,  4, 1, 32'h4, 32'hA5A5_0004);
        // redirect to unaligned 0x103 with two entries, then wrap at top
        tbl[14] = mk(1, 0, 0, 0, 0, 1, 32'h0,  0, 0, 32'h0, 32'h0);
        tbl[15] = mk(0, 0, 0, 0, 1, 1, 32'h0,  0, 0, 32'h0, 32'h0);
        tbl[16] = mk(0, 0, 0, 0, 1, 1, 32'h4,  1, 1, 32'h0, 32'hA5A5_0000);
        tbl[17] = mk(0, 0, 0, 0, 1, 1, 32'h8,  2, 1, 32'h0, 32'hA5A5_0000);
        tbl[18] = mk(0, 1, 1, 32'h103, 1, 1, 32'h100, 0, 0, 32'h0,
                     32'hA5A5_0000);
        tbl[19] = mk(0, 0, 0, 0, 1, 1, 32'h104, 1, 1, 32'h100, 32'hA5A5_0100);
        tbl[20] = mk(0, 1, 1, 32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFFC, 0, 0,
                     32'h100, 32'hA5A5_0100);
        tbl[21] = mk(0, 1, 0, 0, 1, 1, 32'h0, 1, 1, 32'hFFFF_FFFC,
                     32'h5A5A_FFFC);
        tbl[22] = mk(0, 1, 0, 0, 1, 1, 32'h4, 1, 1, 32'h0, 32'hA5A5_0000);

        mem_mode = 1;
        lat      = 0;
        @(negedge clock);
        for (int i = 0; i < 23; i++) begin
            reset       = tbl[i].rst;
            inst_ready  = tbl[i].rdy;
            redirect    = tbl[i].redir;
            redirect_pc = tbl[i].rpc;
            @(negedge clock);
            chk($sformatf("row%0d_req", i), mem_req, tbl[i].req);
            chk($sformatf("row%0d_cnt", i), count, tbl[i].cnt);
            chk($sformatf("row%0d_valid", i), inst_valid, tbl[i].val);
            chk($sformatf("row%0d_pc", i), inst_pc, tbl[i].pc);
            chk($sformatf("row%0d_out", i), inst_out, tbl[i].out);
            if (tbl[i].ca) begin
                chk($sformatf("row%0d_addr", i), mem_addr, tbl[i].addr);
            end
        end
        redirect = 1'b0;

        // slow memory, redirect while the request to 8 is outstanding
        reset      = 1'b1;
        inst_ready = 1'b0;
        lat        = 3;
        @(negedge clock);
        reset = 1'b0;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clock);
            if (mem_req && mem_addr == 32'h8) found = 1;
        end
        chk("lat_reach_addr8", found, 1'b1);
        chk("lat_cnt_before", count, 3'd2);
        @(negedge clock);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clock);
        redirect = 1'b0;
        n = 0;
        while (mem_addr == 32'h8 && n < 10) begin
            chk("drain_req_held", mem_req, 1'b1);
            chk("drain_cnt", count, 3'd0);
            @(negedge clock);
            n++;
        end
        chk("drain_cycles", (n >= 2), 1'b1);
        chk("redir_addr", mem_addr, 32'h100);
        chk("redir_req", mem_req, 1'b1);
        chk("redir_no_push", count, 3'd0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            if (inst_valid) found = 1;
        end
        chk("redir_valid", found, 1'b1);
        chk("redir_first_pc", inst_pc, 32'h100);
        chk("redir_first_out", inst_out, 32'h100 ^ KEY);

        // async reset in the middle of an outstanding request
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clock);
            if (mem_req && mem_addr == 32'h8) found = 1;
        end
        chk("ar_reach_addr8", found, 1'b1);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("ar_req_drop", mem_req, 1'b0);
        chk("ar_cnt_clear", count, 3'd0);
        chk("ar_valid_clear", inst_valid, 1'b0);
        mem_mode = 0;
        man_ack  = 1'b1;
        repeat (3) @(negedge clock);
        chk("ar_ack_in_reset_req", mem_req, 1'b0);
        chk("ar_ack_in_reset_cnt", count, 3'd0);
        man_ack = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        found = 0;
        for (int i = 0; i < 5 && !found; i++) begin
            @(negedge clock);
            if (mem_req) found = 1;
        end
        chk("ar_first_req", found, 1'b1);
        chk("ar_first_addr", mem_addr, 32'h0);
        chk("ar_first_cnt", count, 3'd0);
        mem_mode = 1;
        lat      = 0;
        found    = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clock);
            if (inst_valid) found = 1;
        end
        chk("ar_post_valid", found, 1'b1);
        chk("ar_post_pc", inst_pc, 32'h0);
        chk("ar_post_out", inst_out, KEY);

        // random traffic against the model
        reset      = 1'b1;
        inst_ready = 1'b0;
        mem_mode   = 2;
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            inst_ready  = ($urandom_range(0, 1) == 1);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            end
            @(negedge clock);
            act_a = mem_req ? mem_addr : 32'h0;
            exp_a = m_req ? m_addr : 32'h0;
            chk($sformatf("rand_c%0d", c),
                {mem_req, act_a, count, inst_valid, inst_pc, inst_out},
                {m_req, exp_a, 3'(mq.size()), (mq.size() != 0),
                 m_hpc, m_hins});
        end
        redirect = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
